// File: rtl/cic_adpcm_sequencer.sv
// rtl/cic_adpcm_sequencer.sv - CIC/ADPCM sequencer: CIC control, sample strobes, nibble packing, drain
module cic_adpcm_sequencer #(
  parameter int DECIM          = 64,
  parameter int RST_CYCLES     = 2,
  parameter int WARMUP_SAMPLES = 2,
  parameter int DRAIN_CYCLES   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        block_enable,
  output logic        cic_ce,
  output logic        cic_rst,
  output logic        enc_in_valid,
  input  logic        enc_in_ready,
  input  logic        enc_out_valid,
  input  logic [3:0]  enc_pcm,
  output logic [15:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        overflow,
  output logic        busy
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int FW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(WARMUP_SAMPLES + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_WARMUP,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic [1:0]    nib_cnt_q, nib_cnt_d;
  logic [15:0]   shreg_q, shreg_d;
  logic [15:0]   word_q, word_d;
  logic          word_valid_q, word_valid_d;
  logic          ovf_q, ovf_d;
  logic          enc_in_valid_q, enc_in_valid_d;

  logic          tick;
  logic          reg_free;
  logic          pack_en;
  logic [15:0]   packed_word;

  assign cic_rst      = (state_q == S_IDLE) || (state_q == S_FLUSH);
  assign cic_ce       = (state_q == S_WARMUP) || (state_q == S_RUN);
  assign busy         = (state_q != S_IDLE);
  assign enc_in_valid = enc_in_valid_q;
  assign word_out     = word_q;
  assign word_valid   = word_valid_q;
  assign overflow     = ovf_q;

  // Last phase of a decimation period marks the CIC output sample.
  assign tick        = cic_ce && (phase_q == PW'(DECIM - 1));
  assign reg_free    = !word_valid_q || word_ready;
  assign packed_word = shreg_q | (16'(enc_pcm) << {nib_cnt_q, 2'b00});

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      phase_q        <= '0;
      flush_cnt_q    <= '0;
      tick_cnt_q     <= '0;
      drain_cnt_q    <= '0;
      nib_cnt_q      <= '0;
      shreg_q        <= '0;
      word_q         <= '0;
      word_valid_q   <= 1'b0;
      ovf_q          <= 1'b0;
      enc_in_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      flush_cnt_q    <= flush_cnt_d;
      tick_cnt_q     <= tick_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      nib_cnt_q      <= nib_cnt_d;
      shreg_q        <= shreg_d;
      word_q         <= word_d;
      word_valid_q   <= word_valid_d;
      ovf_q          <= ovf_d;
      enc_in_valid_q <= enc_in_valid_d;
    end
  end

  // Next-state logic: sequencing, strobe generation, packing and drain flush.
  always_comb begin
    state_d        = state_q;
    phase_d        = '0;
    flush_cnt_d    = flush_cnt_q;
    tick_cnt_d     = tick_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    nib_cnt_d      = nib_cnt_q;
    shreg_d        = shreg_q;
    word_d         = word_q;
    word_valid_d   = word_valid_q;
    ovf_d          = ovf_q;
    enc_in_valid_d = 1'b0;
    pack_en        = 1'b0;

    // A word handed downstream frees the output register; a load below may refill it.
    if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end

    if (cic_ce) begin
      phase_d = tick ? '0 : phase_q + PW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (block_enable) begin
          state_d     = S_FLUSH;
          ovf_d       = 1'b0;
          flush_cnt_d = '0;
          tick_cnt_d  = '0;
          drain_cnt_d = '0;
          nib_cnt_d   = '0;
          shreg_d     = '0;
        end
      end
      S_FLUSH: begin
        if (!block_enable) begin
          state_d = S_IDLE;
        end else if (flush_cnt_q == FW'(RST_CYCLES - 1)) begin
          state_d = S_WARMUP;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      S_WARMUP: begin
        if (!block_enable) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (tick_cnt_q == TW'(WARMUP_SAMPLES - 1)) begin
            state_d = S_RUN;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      S_RUN: begin
        pack_en = 1'b1;
        if (tick) begin
          if (enc_in_ready) begin
            enc_in_valid_d = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (!block_enable) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q != DW'(DRAIN_CYCLES)) begin
          pack_en     = 1'b1;
          drain_cnt_d = drain_cnt_q + DW'(1);
        end else if (nib_cnt_q == 2'd0) begin
          state_d = S_IDLE;
        end else if (reg_free) begin
          // Upper slots of shreg are still zero, giving the zero padding.
          word_d       = shreg_q;
          word_valid_d = 1'b1;
          nib_cnt_d    = '0;
          shreg_d      = '0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pack_en && enc_out_valid) begin
      if (nib_cnt_q == 2'd3) begin
        if (reg_free) begin
          word_d       = packed_word;
          word_valid_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
        nib_cnt_d = '0;
        shreg_d   = '0;
      end else begin
        shreg_d   = packed_word;
        nib_cnt_d = nib_cnt_q + 2'd1;
      end
    end
  end

endmodule
